// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive/transmit blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

    // XOR reduction; zero-extension of narrower words does not change the result.
    function automatic logic xor_reduce(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running 16x oversample tick generator; one-clk tick every DVSR clocks.
module uart_baud_gen #(
    parameter int DVSR = 54
) (
    input  logic clk,
    input  logic rst_i,
    output logic tick_o
);

    localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DVSR - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(DVSR - 2);

    logic [CW-1:0] cnt_r;

    // Counter wraps at DVSR-1; tick is registered so it is high exactly while cnt_r == DVSR-1.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            cnt_r  <= {CW{1'b0}};
            tick_o <= 1'b0;
        end else begin
            cnt_r  <= (cnt_r == CNT_LAST) ? {CW{1'b0}} : cnt_r + CW'(1);
            tick_o <= (cnt_r == CNT_PRE);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1
// with a live parity_err_o strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int B        = 8,
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200,
    parameter int SB_TICK  = 16
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         rx_i,
    output logic [B-1:0] dout_o,
    output logic         rx_done_tick_o,
    output logic         frame_err_o,
    output logic         parity_err_o
);

    localparam int DVSR = CLK_FREQ / (OVERSAMPLE * BAUD);
    localparam int NW   = (B > 1) ? $clog2(B) : 1;

    localparam logic [3:0]    S_MID  = 4'(MID_TICK);
    localparam logic [3:0]    S_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(B - 1);

`ifdef UART_RX_PARITY_EN
    localparam uart_rx_state_t AFTER_DATA = PARITY;
`else
    localparam uart_rx_state_t AFTER_DATA = STOP;
`endif

    generate
        if (DVSR < 2) begin : g_dvsr_check
            $error("uart_rx: CLK_FREQ/(16*BAUD) must be at least 2");
        end
    endgenerate

    logic [1:0]     sync_r;
    logic           rx_s;
    logic           tick;
    uart_rx_state_t state_r;
    logic [3:0]     s_r;
    logic [NW-1:0]  n_r;
    logic [B-1:0]   b_r;
`ifdef UART_RX_PARITY_EN
    logic           par_bad_r;
`else
    assign parity_err_o = 1'b0;
`endif

    assign rx_s = sync_r[1];

    uart_baud_gen #(.DVSR(DVSR)) u_baud_gen (
        .clk    (clk),
        .rst_i  (rst_i),
        .tick_o (tick)
    );

    // Two-flop synchronizer for the asynchronous line; resets to the idle (high) level.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rx_i};
        end
    end

    // Receive FSM: start detect, mid-bit sampling, stop/parity check and registered strobes.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_r        <= IDLE;
            s_r            <= 4'd0;
            n_r            <= {NW{1'b0}};
            b_r            <= {B{1'b0}};
            dout_o         <= {B{1'b0}};
            rx_done_tick_o <= 1'b0;
            frame_err_o    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_r      <= 1'b0;
            parity_err_o   <= 1'b0;
`endif
        end else begin
            rx_done_tick_o <= 1'b0;
            frame_err_o    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_o   <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    // Checked every clock so a start bit right after a stop bit is not missed.
                    if (!rx_s) begin
                        state_r <= START;
                        s_r     <= 4'd0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s_r == S_MID) begin
                            if (!rx_s) begin
                                state_r <= DATA;
                                s_r     <= 4'd0;
                                n_r     <= {NW{1'b0}};
                            end else begin
                                state_r <= IDLE;
                            end
                        end else begin
                            s_r <= s_r + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s_r == S_LAST) begin
                            b_r <= {rx_s, b_r[B-1:1]};
                            s_r <= 4'd0;
                            if (n_r == N_LAST) begin
                                state_r <= AFTER_DATA;
                            end else begin
                                n_r <= n_r + 1'b1;
                            end
                        end else begin
                            s_r <= s_r + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (s_r == S_LAST) begin
                            par_bad_r <= rx_s ^ xor_reduce(32'(b_r));
                            s_r       <= 4'd0;
                            state_r   <= STOP;
                        end else begin
                            s_r <= s_r + 4'd1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (s_r == S_STOP) begin
                            state_r <= IDLE;
                            if (!rx_s) begin
                                frame_err_o <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            end else if (par_bad_r) begin
                                parity_err_o <= 1'b1;
`endif
                            end else begin
                                rx_done_tick_o <= 1'b1;
                                dout_o         <= b_r;
                            end
                        end else begin
                            s_r <= s_r + 4'd1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 100 MHz / 115200 baud (864 clk per bit).
module tb_uart_rx;

    localparam int BIT_CLK = 864;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int STROBE_MID = (2 * FRAME_BITS - 1) * BIT_CLK / 2;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       rx_i;
    logic [7:0] dout_o;
    logic       rx_done_tick_o;
    logic       frame_err_o;
    logic       parity_err_o;

    uart_rx #(
        .B        (8),
        .CLK_FREQ (100_000_000),
        .BAUD     (115200),
        .SB_TICK  (16)
    ) dut (
        .clk            (clk),
        .rst_i          (rst_i),
        .rx_i           (rx_i),
        .dout_o         (dout_o),
        .rx_done_tick_o (rx_done_tick_o),
        .frame_err_o    (frame_err_o),
        .parity_err_o   (parity_err_o)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         n_done = 0;
    int         n_fe = 0;
    int         n_pe = 0;
    int         n_multi = 0;
    int         t_start = 0;
    logic [7:0] rx_bytes[$];
    int         t_done[$];

    // Strobe monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rx_done_tick_o) begin
            n_done = n_done + 1;
            rx_bytes.push_back(dout_o);
            t_done.push_back(cyc);
        end
        if (frame_err_o) n_fe = n_fe + 1;
        if (parity_err_o) n_pe = n_pe + 1;
        if (32'(rx_done_tick_o) + 32'(frame_err_o) + 32'(parity_err_o) > 1) n_multi = n_multi + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bit_for(input logic v, input int ncyc);
        rx_i = v;
        repeat (ncyc) @(posedge clk);
        #1;
    endtask

    // stop_low > 0 holds the stop bit low for that many clocks before releasing it.
    task automatic send_frame(input logic [7:0] d, input int stop_low, input logic par_flip);
        t_start = cyc;
        bit_for(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) bit_for(d[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
        bit_for((^d) ^ par_flip, BIT_CLK);
`endif
        if (stop_low > 0) begin
            bit_for(1'b0, stop_low);
            bit_for(1'b1, BIT_CLK - stop_low);
        end else begin
            bit_for(1'b1, BIT_CLK);
        end
    endtask

    int d0, f0, p0, gap;

    initial begin
        rst_i = 1'b1;
        rx_i  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_dout", 32'(dout_o), 32'h00);
        check_eq("rst_done", 32'(rx_done_tick_o), 32'h0);
        check_eq("rst_ferr", 32'(frame_err_o), 32'h0);
        check_eq("rst_perr", 32'(parity_err_o), 32'h0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        bit_for(1'b1, 2 * BIT_CLK);

        // Clean 0xA5 with latency check
        d0 = n_done; f0 = n_fe; p0 = n_pe;
        send_frame(8'hA5, 0, 1'b0);
        check_eq("a5_done_cnt", 32'(n_done - d0), 32'd1);
        check_eq("a5_dout", 32'(dout_o), 32'hA5);
        check_eq("a5_ferr_cnt", 32'(n_fe - f0), 32'd0);
        check_eq("a5_perr_cnt", 32'(n_pe - p0), 32'd0);
        if (t_done.size() > 0) begin
            gap = t_done[t_done.size() - 1] - t_start;
            check_eq("a5_latency_in_window",
                     32'(gap > STROBE_MID - 70 && gap < STROBE_MID + 70), 32'd1);
        end else begin
            check_eq("a5_latency_seen", 32'd0, 32'd1);
        end
        bit_for(1'b1, 2 * BIT_CLK);

        // 0x3C with a low stop bit: framing error, dout holds 0xA5
        d0 = n_done; f0 = n_fe;
        send_frame(8'h3C, 540, 1'b0);
        bit_for(1'b1, 2 * BIT_CLK);
        check_eq("fe_ferr_cnt", 32'(n_fe - f0), 32'd1);
        check_eq("fe_done_cnt", 32'(n_done - d0), 32'd0);
        check_eq("fe_dout_held", 32'(dout_o), 32'hA5);

        // 216-clk low glitch is a false start
        d0 = n_done; f0 = n_fe;
        bit_for(1'b0, 216);
        bit_for(1'b1, 3 * BIT_CLK);
        check_eq("glitch_done_cnt", 32'(n_done - d0), 32'd0);
        check_eq("glitch_ferr_cnt", 32'(n_fe - f0), 32'd0);
        send_frame(8'h3C, 0, 1'b0);
        check_eq("post_glitch_done_cnt", 32'(n_done - d0), 32'd1);
        check_eq("post_glitch_dout", 32'(dout_o), 32'h3C);
        bit_for(1'b1, 2 * BIT_CLK);

        // Back-to-back 0x00, 0xFF, 0x55 with no idle gap
        rx_bytes.delete();
        t_done.delete();
        send_frame(8'h00, 0, 1'b0);
        send_frame(8'hFF, 0, 1'b0);
        send_frame(8'h55, 0, 1'b0);
        bit_for(1'b1, 2 * BIT_CLK);
        check_eq("b2b_done_cnt", 32'(rx_bytes.size()), 32'd3);
        if (rx_bytes.size() == 3 && t_done.size() == 3) begin
            check_eq("b2b_byte0", 32'(rx_bytes[0]), 32'h00);
            check_eq("b2b_byte1", 32'(rx_bytes[1]), 32'hFF);
            check_eq("b2b_byte2", 32'(rx_bytes[2]), 32'h55);
            for (int i = 1; i < 3; i++) begin
                gap = t_done[i] - t_done[i-1];
                check_eq($sformatf("b2b_gap%0d_in_window", i),
                         32'(gap >= FRAME_BITS * BIT_CLK - 55 && gap <= FRAME_BITS * BIT_CLK + 55), 32'd1);
            end
        end

        // Reset in the middle of data bit 3 of 0x81; transmitter also returns to idle
        d0 = n_done; f0 = n_fe;
        bit_for(1'b0, BIT_CLK);
        bit_for(1'b1, BIT_CLK);
        bit_for(1'b0, BIT_CLK);
        bit_for(1'b0, BIT_CLK);
        bit_for(1'b0, BIT_CLK / 2);
        rst_i = 1'b1;
        rx_i  = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check_eq("abort_dout_reset", 32'(dout_o), 32'h00);
        @(posedge clk); #1;
        bit_for(1'b1, 12 * BIT_CLK);
        check_eq("abort_done_cnt", 32'(n_done - d0), 32'd0);
        check_eq("abort_ferr_cnt", 32'(n_fe - f0), 32'd0);
        send_frame(8'h81, 0, 1'b0);
        check_eq("post_abort_done_cnt", 32'(n_done - d0), 32'd1);
        check_eq("post_abort_dout", 32'(dout_o), 32'h81);
        bit_for(1'b1, 2 * BIT_CLK);
        check_eq("no_parity_err_so_far", 32'(n_pe), 32'd0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: even parity bit is 1
        d0 = n_done; p0 = n_pe;
        send_frame(8'h07, 0, 1'b0);
        check_eq("par_ok_done_cnt", 32'(n_done - d0), 32'd1);
        check_eq("par_ok_dout", 32'(dout_o), 32'h07);
        bit_for(1'b1, 2 * BIT_CLK);
        d0 = n_done; p0 = n_pe; f0 = n_fe;
        send_frame(8'h07, 0, 1'b1);
        bit_for(1'b1, 2 * BIT_CLK);
        check_eq("par_bad_perr_cnt", 32'(n_pe - p0), 32'd1);
        check_eq("par_bad_done_cnt", 32'(n_done - d0), 32'd0);
        check_eq("par_bad_ferr_cnt", 32'(n_fe - f0), 32'd0);
`endif

        check_eq("strobes_exclusive", 32'(n_multi), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART serial receiver for the image-processing receive path. Samples the asynchronous `rx_i` line at 16× the baud rate, deframes 8N1 characters (8E1 when parity is compiled in), and emits each good byte with a one-cycle strobe. The strobe and byte connect directly to the write port (`wr`, `w_data`) of the RX FIFO.

## Interface
- `B`, 8: data bits per character; also the width of `dout_o`.
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line baud rate.
- `SB_TICK`, 16: oversample ticks in the stop bit (16 = 1 stop bit).
- Derived localparam `DVSR = CLK_FREQ / (16*BAUD)`, integer-truncated. `DVSR >= 2` is required and is checked at elaboration.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `rx_i`  in  1  asynchronous serial input; idles high.
- `dout_o`  out  B  last good received byte, LSB first on the wire.
- `rx_done_tick_o`  out  1  one-cycle strobe; `dout_o` is valid in the same cycle. Drives FIFO `wr`.
- `frame_err_o`  out  1  one-cycle strobe: the stop bit was sampled low.
- `parity_err_o`  out  1  one-cycle strobe: parity mismatch. Tied to 0 when parity is not compiled in.

## Operation
- `rx_i` passes through a 2-FF synchronizer (reset value 1) to give `rx_s`.
- Baud tick: a free-running counter counts 0..DVSR-1. `tick` is high for one clk when the count equals DVSR-1.
- FSM states: IDLE, START, DATA, PARITY (only when `UART_RX_PARITY_EN` is defined), STOP.
- Counters:
  - `s`, 4 bits: ticks within the current bit.
  - `n`, width $clog2(B): data bit index.
  - `b`: B-bit shift register.
- IDLE:
  - If `rx_s == 0`, go to START and clear `s`.
  - Evaluated every clk, not only on `tick`.
- START, on `tick`:
  - If `s == 7` (mid-bit) and `rx_s == 0`, go to DATA and clear `s` and `n`.
  - If `s == 7` and `rx_s == 1`, this is a false start: return to IDLE with no outputs.
  - Otherwise `s++`.
- DATA, on `tick`:
  - At `s == 15`: shift `b <= {rx_s, b[B-1:1]}` and clear `s`.
  - If also `n == B-1`, go to PARITY or STOP; otherwise `n++`.
- PARITY, on `tick`:
  - At `s == 15`: latch `par_bad = rx_s ^ (^b)` (even parity), clear `s`, go to STOP.
- STOP, on `tick`:
  - At `s == SB_TICK-1`, return to IDLE and issue exactly one strobe:
    - If `rx_s == 0`: `frame_err_o` (framing takes priority).
    - Else if `par_bad`: `parity_err_o`.
    - Else: `rx_done_tick_o`, and load `dout_o <= b`.
- `dout_o` changes only on `rx_done_tick_o`. Errored bytes are dropped and never reach the FIFO.
- A break (stop bit low, line held low) flags `frame_err_o`. The FSM then re-enters START from IDLE and runs false-start and framing checks again.

## Timing
- Reset values: FSM IDLE; `s`, `n`, `b` = 0; `dout_o` = 0; all strobes 0; baud counter 0; synchronizer FFs 1.
- `rst_i` asserted in any state aborts the frame. No strobe is issued for the aborted frame.
- Strobes are registered and last exactly one clk. At most one strobe per frame; the three strobes are mutually exclusive.
- Sampling point: mid-bit, ±1 tick (1/16 bit) of jitter from the free-running baud counter, plus 2 clk synchronizer delay.
- Strobe timing: about 9.5 bit times after the falling edge of the start bit (10.5 with parity).
- Back-to-back frames with zero idle gap are supported, because IDLE detects the next start bit within 1 clk.
- The downstream FIFO may be full; this block has no backpressure and does not stall.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state and even-parity check are present, and `parity_err_o` is live. Frame format is 8E1.
- `UART_RX_PARITY_EN` undefined: no PARITY state; DATA goes straight to STOP. `parity_err_o` is constant 0. Frame format is 8N1.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t`
  - localparam `OVERSAMPLE = 16`
  - localparam `MID_TICK = 7`
- Sub-module `uart_baud_gen`, parameter `DVSR`, ports `clk`, `rst_i`, `tick_o`. It will also be reused by the future `uart_tx`.
- The synchronizer stays inline.

## Test plan
Defaults: CLK_FREQ = 100 MHz, BAUD = 115200, DVSR = 54, 1 bit = 864 clk.
- Send 0xA5 as 8N1 → one `rx_done_tick_o` pulse about 8200 clk after the start edge; `dout_o = 0xA5`; no error strobes.
- Low glitch of 216 clk (4 ticks), then line high → no strobe; FSM back in IDLE; a following 0x3C is received correctly.
- 0x3C with the stop bit held low → one `frame_err_o` pulse; no `rx_done_tick_o`; `dout_o` keeps its previous value.
- Frames 0x00, 0xFF, 0x55 with no idle gap → three `rx_done_tick_o` pulses 8640 ± 54 clk apart, carrying the correct bytes.
- One-cycle `rst_i` during data bit 3 of 0x81 → no strobe for that frame; the next clean 0x81 gives `dout_o = 0x81`.
- With `UART_RX_PARITY_EN`:
  - 0x07 with parity bit 1 → `rx_done_tick_o`, `dout_o = 0x07`.
  - 0x07 with parity bit 0 → one `parity_err_o` pulse; no done strobe.
